// File: rtl/game_pkg.sv
// Shared definitions for the factorization game: STATE bus codes, RESULT bit
// positions, score/round widths and small helpers.
package game_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0000,
    ST_LOAD     = 4'b0001,
    ST_WAIT_Q   = 4'b0010,
    ST_QUESTION = 4'b0011,
    ST_INPUT    = 4'b0100,
    ST_JUDGE    = 4'b0101,
    ST_DRAW     = 4'b0110,
    ST_GOOD     = 4'b1000,
    ST_OUCH     = 4'b1001,
    ST_WIN      = 4'b1010,
    ST_LOSE     = 4'b1011
  } game_state_e;

  localparam int unsigned RES_OWN_BIT = 0;
  localparam int unsigned RES_OPP_BIT = 1;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned ROUND_W = 4;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/game_state_ctrl_timer.sv
// cycle_timer: up-counter with synchronous clear and enable; done_o flags the
// cycle in which the count equals last_i while counting is enabled.
module cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = en_i && (cnt_q == last_i);

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level game sequencer: drives the STATE bus, rounds and scores.
// Optional answer timeout in INPUT is enabled by defining GAME_INPUT_TMO_EN.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned ROUNDS        = 5,
  parameter int unsigned Q_SHOW_CYC    = 50_000_000,
  parameter int unsigned RES_SHOW_CYC  = 100_000_000,
  parameter int unsigned INPUT_TMO_CYC = 500_000_000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               QUE_OK,
  input  logic               DEC,
  input  logic               RES_VALID,
  input  logic [1:0]         RESULT,
  output logic [3:0]         STATE,
  output logic               Q_REQ,
  output logic [ROUND_W-1:0] ROUND,
  output logic [SCORE_W-1:0] SCORE_A,
  output logic [SCORE_W-1:0] SCORE_B,
  output logic               GAME_OVER
);

  localparam int unsigned TMR_W = $clog2(max3(Q_SHOW_CYC, RES_SHOW_CYC, INPUT_TMO_CYC) + 1);

  game_state_e        state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic               q_req_q, q_req_d;
  logic               game_over_q, game_over_d;

  logic               tmr_en;
  logic [TMR_W-1:0]   tmr_last;
  logic               tmr_done;

  cycle_timer #(.W(TMR_W)) u_timer (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (state_d != state_q),
    .en_i   (tmr_en),
    .last_i (tmr_last),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    game_over_d = game_over_q;
    tmr_en      = 1'b0;
    tmr_last    = '0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d   = ST_LOAD;
          round_d   = '0;
          score_a_d = '0;
          score_b_d = '0;
        end
      end
      ST_LOAD:   state_d = ST_WAIT_Q;
      ST_WAIT_Q: if (QUE_OK) state_d = ST_QUESTION;
      ST_QUESTION: begin
        tmr_en   = 1'b1;
        tmr_last = TMR_W'(Q_SHOW_CYC - 1);
        if (tmr_done) state_d = ST_INPUT;
      end
      ST_INPUT: begin
`ifdef GAME_INPUT_TMO_EN
        tmr_en   = 1'b1;
        tmr_last = TMR_W'(INPUT_TMO_CYC - 1);
        if (DEC) begin
          state_d = ST_JUDGE;
        end else if (tmr_done) begin
          state_d   = ST_OUCH;
          score_b_d = sat_inc(score_b_q);
        end
`else
        if (DEC) state_d = ST_JUDGE;
`endif
      end
      ST_JUDGE: begin
        if (RES_VALID) begin
          if (RESULT[RES_OWN_BIT] && !RESULT[RES_OPP_BIT]) begin
            state_d   = ST_GOOD;
            score_a_d = sat_inc(score_a_q);
          end else if (!RESULT[RES_OWN_BIT] && RESULT[RES_OPP_BIT]) begin
            state_d   = ST_OUCH;
            score_b_d = sat_inc(score_b_q);
          end else begin
            state_d = ST_DRAW;
          end
        end
      end
      ST_GOOD, ST_OUCH, ST_DRAW: begin
        // DRAW doubles as the final tie state; GAME_OVER tells the two apart.
        if (state_q == ST_DRAW && game_over_q) begin
          if (START) begin
            state_d     = ST_IDLE;
            game_over_d = 1'b0;
          end
        end else begin
          tmr_en   = 1'b1;
          tmr_last = TMR_W'(RES_SHOW_CYC - 1);
          if (tmr_done) begin
            if (round_q < ROUND_W'(ROUNDS - 1)) begin
              round_d = round_q + 1'b1;
              state_d = ST_LOAD;
            end else begin
              game_over_d = 1'b1;
              if (score_a_q > score_b_q)      state_d = ST_WIN;
              else if (score_a_q < score_b_q) state_d = ST_LOSE;
              else                            state_d = ST_DRAW;
            end
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (START) begin
          state_d     = ST_IDLE;
          game_over_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        game_over_d = 1'b0;
      end
    endcase

    q_req_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      score_a_q   <= '0;
      score_b_q   <= '0;
      q_req_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      score_a_q   <= score_a_d;
      score_b_q   <= score_b_d;
      q_req_q     <= q_req_d;
      game_over_q <= game_over_d;
    end
  end

  assign STATE     = state_q;
  assign Q_REQ     = q_req_q;
  assign ROUND     = round_q;
  assign SCORE_A   = score_a_q;
  assign SCORE_B   = score_b_q;
  assign GAME_OVER = game_over_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl with ROUNDS=2, Q_SHOW_CYC=4,
// RES_SHOW_CYC=3, INPUT_TMO_CYC=6; expected outputs go through a scoreboard queue.
module tb_game_state_ctrl;

  localparam logic [3:0] S_IDLE = 4'b0000, S_LOAD = 4'b0001, S_WQ   = 4'b0010,
                         S_QU   = 4'b0011, S_IN   = 4'b0100, S_JU   = 4'b0101,
                         S_DR   = 4'b0110, S_GD   = 4'b1000, S_OU   = 4'b1001,
                         S_WIN  = 4'b1010, S_LOSE = 4'b1011;

  // drive vector bits: {RST, START, QUE_OK, DEC, RES_VALID}
  localparam logic [4:0] D_NONE = 5'b00000, D_RST = 5'b10000, D_ST = 5'b01000,
                         D_QOK  = 5'b00100, D_DEC = 5'b00010, D_RV = 5'b00001;

  logic       CLK, RST, START, QUE_OK, DEC, RES_VALID;
  logic [1:0] RESULT;
  logic [3:0] STATE, ROUND, SCORE_A, SCORE_B;
  logic       Q_REQ, GAME_OVER;

  game_state_ctrl #(
    .ROUNDS        (2),
    .Q_SHOW_CYC    (4),
    .RES_SHOW_CYC  (3),
    .INPUT_TMO_CYC (6)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .QUE_OK    (QUE_OK),
    .DEC       (DEC),
    .RES_VALID (RES_VALID),
    .RESULT    (RESULT),
    .STATE     (STATE),
    .Q_REQ     (Q_REQ),
    .ROUND     (ROUND),
    .SCORE_A   (SCORE_A),
    .SCORE_B   (SCORE_B),
    .GAME_OVER (GAME_OVER)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [17:0] exp;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [3:0]  e_r, e_a, e_b;

  // observed/expected layout: {STATE, Q_REQ, GAME_OVER, ROUND, SCORE_A, SCORE_B}
  task automatic check_eq(input string tag, input logic [17:0] act, input logic [17:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got state=%h qreq=%b go=%b round=%h a=%h b=%h, expected state=%h qreq=%b go=%b round=%h a=%h b=%h",
               tag, act[17:14], act[13], act[12], act[11:8], act[7:4], act[3:0],
               exp[17:14], exp[13], exp[12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic cyc(input string tag, input logic [4:0] drv, input logic [1:0] res,
                     input logic [3:0] es, input logic eq, input logic eg);
    sb_item_t it;
    {RST, START, QUE_OK, DEC, RES_VALID} = drv;
    RESULT = res;
    it.tag = tag;
    it.exp = {es, eq, eg, e_r, e_a, e_b};
    sb_q.push_back(it);
    @(posedge CLK);
    #1;
    {RST, START, QUE_OK, DEC, RES_VALID} = D_NONE;
    RESULT = 2'b00;
    it = sb_q.pop_front();
    check_eq(it.tag, {STATE, Q_REQ, GAME_OVER, ROUND, SCORE_A, SCORE_B}, it.exp);
  endtask

  task automatic hold(input string tag, input int unsigned n, input logic [3:0] es, input logic eg);
    for (int unsigned i = 0; i < n; i++) cyc(tag, D_NONE, 2'b00, es, 1'b0, eg);
  endtask

  // From LOAD: WAIT_Q, one cycle later QUESTION for 4 cycles, then INPUT.
  task automatic to_input(input string tag);
    cyc({tag, "_wq"}, D_NONE, 2'b00, S_WQ, 1'b0, 1'b0);
    cyc({tag, "_wq2"}, D_NONE, 2'b00, S_WQ, 1'b0, 1'b0);
    cyc({tag, "_qu"}, D_QOK, 2'b00, S_QU, 1'b0, 1'b0);
    hold({tag, "_qu_hold"}, 3, S_QU, 1'b0);
    cyc({tag, "_in"}, D_NONE, 2'b00, S_IN, 1'b0, 1'b0);
  endtask

  // From INPUT: DEC, one idle JUDGE cycle, RES_VALID, then result held 3 cycles.
  task automatic judge_round(input string tag, input logic [1:0] res, input logic [3:0] es);
    cyc({tag, "_dec"}, D_DEC, 2'b00, S_JU, 1'b0, 1'b0);
    cyc({tag, "_ju_wait"}, D_NONE, 2'b00, S_JU, 1'b0, 1'b0);
    if (es == S_GD) e_a = e_a + 1'b1;
    if (es == S_OU) e_b = e_b + 1'b1;
    cyc({tag, "_res"}, D_RV, res, es, 1'b0, 1'b0);
    hold({tag, "_res_hold"}, 2, es, 1'b0);
  endtask

  initial begin
    {RST, START, QUE_OK, DEC, RES_VALID} = D_NONE;
    RESULT = 2'b00;
    e_r = '0; e_a = '0; e_b = '0;

    cyc("reset", D_RST, 2'b00, S_IDLE, 1'b0, 1'b0);
    cyc("idle_hold", D_NONE, 2'b00, S_IDLE, 1'b0, 1'b0);

    // Game 1: GOOD then OUCH -> final DRAW
    cyc("g1_start", D_ST, 2'b00, S_LOAD, 1'b1, 1'b0);
    to_input("g1r0");
    cyc("g1_stray_rv", D_RV, 2'b01, S_IN, 1'b0, 1'b0);
    judge_round("g1r0", 2'b01, S_GD);
    e_r = 4'd1;
    cyc("g1_next_round", D_NONE, 2'b00, S_LOAD, 1'b1, 1'b0);
    to_input("g1r1");
    judge_round("g1r1", 2'b10, S_OU);
    cyc("g1_final_draw", D_NONE, 2'b00, S_DR, 1'b0, 1'b1);
    hold("g1_final_hold", 2, S_DR, 1'b1);
    cyc("g1_restart", D_ST, 2'b00, S_IDLE, 1'b0, 1'b0);

    // Game 2: two GOOD rounds -> WIN; START ignored in INPUT
    e_r = '0; e_a = '0; e_b = '0;
    cyc("g2_start", D_ST, 2'b00, S_LOAD, 1'b1, 1'b0);
    to_input("g2r0");
    cyc("g2_start_in_input", D_ST, 2'b00, S_IN, 1'b0, 1'b0);
    judge_round("g2r0", 2'b01, S_GD);
    e_r = 4'd1;
    cyc("g2_next_round", D_NONE, 2'b00, S_LOAD, 1'b1, 1'b0);
    to_input("g2r1");
    judge_round("g2r1", 2'b01, S_GD);
    cyc("g2_win", D_NONE, 2'b00, S_WIN, 1'b0, 1'b1);
    cyc("g2_win_hold", D_RV, 2'b10, S_WIN, 1'b0, 1'b1);
    cyc("g2_restart", D_ST, 2'b00, S_IDLE, 1'b0, 1'b0);

    // Game 3: reset in JUDGE with a simultaneous RES_VALID
    e_r = '0; e_a = '0; e_b = '0;
    cyc("g3_start", D_ST, 2'b00, S_LOAD, 1'b1, 1'b0);
    to_input("g3r0");
    cyc("g3_dec", D_DEC, 2'b00, S_JU, 1'b0, 1'b0);
    cyc("g3_rst_in_judge", D_RST | D_RV, 2'b01, S_IDLE, 1'b0, 1'b0);
    cyc("g3_rv_in_idle", D_RV, 2'b01, S_IDLE, 1'b0, 1'b0);

    // Game 4: round DRAW (11) then OUCH -> LOSE
    cyc("g4_start", D_ST, 2'b00, S_LOAD, 1'b1, 1'b0);
    to_input("g4r0");
    judge_round("g4r0", 2'b11, S_DR);
    e_r = 4'd1;
    cyc("g4_next_round", D_NONE, 2'b00, S_LOAD, 1'b1, 1'b0);
    to_input("g4r1");
    judge_round("g4r1", 2'b10, S_OU);
    cyc("g4_lose", D_NONE, 2'b00, S_LOSE, 1'b0, 1'b1);
    cyc("g4_restart", D_ST, 2'b00, S_IDLE, 1'b0, 1'b0);

    // Game 5: answer timeout behaviour, then round DRAW (00)
    e_r = '0; e_a = '0; e_b = '0;
    cyc("g5_start", D_ST, 2'b00, S_LOAD, 1'b1, 1'b0);
    to_input("g5r0");
`ifdef GAME_INPUT_TMO_EN
    hold("g5_in_wait", 5, S_IN, 1'b0);
    e_b = 4'd1;
    cyc("g5_timeout", D_NONE, 2'b00, S_OU, 1'b0, 1'b0);
    hold("g5_ouch_hold", 2, S_OU, 1'b0);
`else
    hold("g5_in_wait", 8, S_IN, 1'b0);
    judge_round("g5r0", 2'b10, S_OU);
`endif
    e_r = 4'd1;
    cyc("g5_next_round", D_NONE, 2'b00, S_LOAD, 1'b1, 1'b0);
    to_input("g5r1");
    hold("g5r1_in_wait", 5, S_IN, 1'b0);
    judge_round("g5r1", 2'b00, S_DR);
    cyc("g5_lose", D_NONE, 2'b00, S_LOSE, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level sequencer for the factorization game; drives the 4-bit STATE bus that the answer-input/question-display block, the judge and the 7-seg drivers decode.
- Runs a fixed number of rounds: request question, show it, open answer entry, wait for judgement, show round result, then final WIN/LOSE/DRAW.
- Keeps round counter and both players' scores.

Parameters:
- ROUNDS, 5: rounds per game (1..15).
- Q_SHOW_CYC, 50_000_000: cycles STATE stays QUESTION before INPUT opens.
- RES_SHOW_CYC, 100_000_000: cycles a per-round result (GOOD/OUCH/DRAW) is held.
- INPUT_TMO_CYC, 500_000_000: answer timeout in cycles (used only with the optional feature).

Ports:
- CLK  in  1  system clock; one clock; reset is synchronous and active-high.
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle pulse, start/restart game.
- QUE_OK  in  1  level: question stored by the input block.
- DEC  in  1  single-cycle pulse, answer decided by player.
- RES_VALID  in  1  single-cycle pulse, judge result available.
- RESULT  in  2  [0]=own answer correct, [1]=opponent correct; sampled only with RES_VALID.
- STATE  out  4  game state code.
- Q_REQ  out  1  single-cycle request for next question.
- ROUND  out  4  current round index, 0-based.
- SCORE_A  out  4  own score.
- SCORE_B  out  4  opponent score.
- GAME_OVER  out  1  high while in a final state.

Behaviour:
- Codes: IDLE 0000, LOAD 0001, WAIT_Q 0010, QUESTION 0011, INPUT 0100, JUDGE 0101, DRAW 0110, GOOD 1000, OUCH 1001, WIN 1010, LOSE 1011. Codes 0111 and 11xx are unreachable; if entered, go to IDLE next cycle.
- Reset, checked every edge and overriding all other inputs: STATE=IDLE, Q_REQ=0, ROUND=0, SCORE_A=SCORE_B=0, GAME_OVER=0, timer=0.
- IDLE: START -> LOAD; clears ROUND and both scores.
- LOAD: Q_REQ=1 for exactly this one cycle -> WAIT_Q.
- WAIT_Q: waits for QUE_OK=1 -> QUESTION, timer cleared. No timeout.
- QUESTION: timer counts up; when timer==Q_SHOW_CYC-1 -> INPUT, timer cleared.
- INPUT:
  - DEC -> JUDGE on the next edge.
  - START is ignored here.
- JUDGE: RES_VALID -> result state, scored as follows:
  - RESULT=01 -> GOOD, SCORE_A+1.
  - RESULT=10 -> OUCH, SCORE_B+1.
  - RESULT=11 or 00 -> DRAW, no score change.
  - Scores saturate at 15.
  - RES_VALID outside JUDGE is ignored.
- GOOD/OUCH/DRAW (round result): hold RES_SHOW_CYC cycles, then:
  - if ROUND<ROUNDS-1: ROUND+1 -> LOAD.
  - else final: SCORE_A>SCORE_B -> WIN; SCORE_A<SCORE_B -> LOSE; equal -> DRAW with GAME_OVER=1.
- Final states (WIN, LOSE, final DRAW): GAME_OVER=1; hold until START -> IDLE.
  - GAME_OVER distinguishes a final DRAW from a round DRAW.
- Timer: single up-counter, wide enough for the largest parameter; cleared on every state change.
- STATE, Q_REQ and GAME_OVER are registered outputs; latency from a trigger input to the new STATE is 1 cycle.

Optional Feature:
- Macro: GAME_INPUT_TMO_EN.
- Defined:
  - INPUT timer counts; timer==INPUT_TMO_CYC-1 without DEC -> OUCH directly, SCORE_B+1, judge skipped.
  - DEC and timeout in the same cycle: DEC wins -> JUDGE.
- Undefined: INPUT waits indefinitely for DEC; INPUT_TMO_CYC is unused.

Decomposition:
- Shared package game_pkg: 4-bit state codes as localparams/enum (used by this block, the input block, the judge and the 7-seg decoders), RESULT bit positions, score width.
- One natural sub-module: cycle_timer (load/clear, count, done flag), reused for show and timeout timing.

Test Plan:
- Tests use ROUNDS=2, Q_SHOW_CYC=4, RES_SHOW_CYC=3, INPUT_TMO_CYC=6.
- Reset mid-JUDGE: STATE=0000, scores=0 on the cycle after RST; RES_VALID during RST is ignored.
- Nominal flow: START -> LOAD for one cycle with Q_REQ=1 -> WAIT_Q.
  - QUE_OK high 2 cycles later -> QUESTION for exactly 4 cycles -> INPUT.
- Round result: DEC -> JUDGE; RES_VALID with RESULT=01 -> GOOD, SCORE_A=1; held 3 cycles -> LOAD, ROUND=1.
- Final result: round 2 with RESULT=10 -> OUCH, SCORE_B=1; then final DRAW (0110) with GAME_OVER=1; START -> IDLE.
- Final WIN: two rounds of RESULT=01 -> WIN (1010). A stray RES_VALID in INPUT is ignored and STATE stays 0100.
- Timeout (GAME_INPUT_TMO_EN defined):
  - No DEC for 6 cycles -> OUCH, SCORE_B+1.
  - DEC on cycle 6 -> JUDGE instead.
